// File: rtl/stopwatch_display.sv
`timescale 1ns/1ps
// stopwatch_display
// Converts binary minutes/seconds from stopwatch_top into BCD with a sequential
// double-dabble converter, then drives a 4-digit multiplexed 7-segment display
// showing MM.SS. The whole display blinks while the stopwatch is paused.
// Optional feature macro: STOPWATCH_DISPLAY_LZB_EN (blank a leading zero in the
// minutes-tens digit). The default build shows all four digits.
module stopwatch_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  minutes,
    input  logic [5:0]  seconds,
    input  logic [1:0]  status,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [15:0] bcd_out,
    output logic        ovf,
    output logic        busy
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic       DP_ON   = ~DP_OFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // One double-dabble iteration on {bcd[7:0], bin[7:0]}: add-3 on BCD nibbles >= 5, then shift left.
    function automatic logic [15:0] dd_step(input logic [15:0] r);
        logic [15:0] t;
        t = r;
        if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
        else                 t[11:8] = t[11:8];
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        else                  t[15:12] = t[15:12];
        return {t[14:0], 1'b0};
    endfunction

    // Active-high {g,f,e,d,c,b,a} pattern; non-decimal codes are blank.
    function automatic logic [6:0] seg7_pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Map an active-high pattern onto the board's segment polarity.
    function automatic logic [6:0] seg_pol(input logic [6:0] p);
        return (SEG_ACTIVE_LOW != 0) ? ~p : p;
    endfunction

    // ---------------- converter ----------------
    conv_state_e  state_q, state_d;
    logic [13:0]  in_q;
    logic [13:0]  last_q;
    logic [2:0]   step_q;
    logic [15:0]  min_sr_q, sec_sr_q;
    logic         ovf_snap_q;
    logic [15:0]  bcd_q;
    logic         ovf_q;
    logic         busy_q, busy_d;
    logic         capture_s, shift_en_s, commit_s;
    logic [7:0]   min_clamp_s;
    logic [5:0]   sec_clamp_s;
    logic         ovf_clamp_s;

    // Clamp the registered input snapshot to displayable range and flag clamping.
    always_comb begin
        min_clamp_s = in_q[13:6];
        sec_clamp_s = in_q[5:0];
        ovf_clamp_s = 1'b0;
        if (in_q[13:6] > 8'd99) begin
            min_clamp_s = 8'd99;
            ovf_clamp_s = 1'b1;
        end else begin
            min_clamp_s = in_q[13:6];
        end
        if (in_q[5:0] > 6'd59) begin
            sec_clamp_s = 6'd59;
            ovf_clamp_s = 1'b1;
        end else begin
            sec_clamp_s = in_q[5:0];
        end
    end

    // Converter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Converter next-state: start on a changed input, 8 shift cycles, one commit cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_q != last_q) state_d = ST_SHIFT;
                else                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                if (step_q == 3'd7) state_d = ST_COMMIT;
                else                state_d = ST_SHIFT;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Converter outputs: datapath strobes and busy (also high while a change is pending).
    always_comb begin
        capture_s  = (state_q == ST_IDLE) && (in_q != last_q);
        shift_en_s = (state_q == ST_SHIFT);
        commit_s   = (state_q == ST_COMMIT);
        busy_d     = (state_d != ST_IDLE) || (in_q != last_q) ||
                     ({minutes, seconds} != last_q);
    end

    // Converter datapath: input register, snapshot, shift iterations and commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q       <= 14'h0000;
            last_q     <= 14'h0000;
            step_q     <= 3'd0;
            min_sr_q   <= 16'h0000;
            sec_sr_q   <= 16'h0000;
            ovf_snap_q <= 1'b0;
            bcd_q      <= 16'h0000;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            in_q   <= {minutes, seconds};
            busy_q <= busy_d;
            if (capture_s) begin
                last_q     <= in_q;
                min_sr_q   <= {8'h00, min_clamp_s};
                sec_sr_q   <= {8'h00, 2'b00, sec_clamp_s};
                ovf_snap_q <= ovf_clamp_s;
                step_q     <= 3'd0;
            end else if (shift_en_s) begin
                min_sr_q <= dd_step(min_sr_q);
                sec_sr_q <= dd_step(sec_sr_q);
                step_q   <= step_q + 3'd1;
            end
            if (commit_s) begin
                bcd_q <= {min_sr_q[15:8], sec_sr_q[15:8]};
                ovf_q <= ovf_snap_q;
            end
        end
    end

    // ---------------- scan and blink ----------------
    logic [RW-1:0] refresh_q;
    logic [1:0]    digit_q;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          refresh_wrap_s, frame_evt_s, paused_s, blank_s, lzb_s;
    logic [3:0]    digit_bcd_s;

    // Frame counter and blink phase; both held at zero whenever not paused.
    always_comb begin
        refresh_wrap_s = (refresh_q == RW'(REFRESH_DIV - 1));
        frame_evt_s    = refresh_wrap_s && (digit_q == 2'd3);
        paused_s       = (status == 2'b10);
        frame_d        = frame_q;
        blink_d        = blink_q;
        if (!paused_s) begin
            frame_d = {FW{1'b0}};
            blink_d = 1'b0;
        end else if (frame_evt_s) begin
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = {FW{1'b0}};
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FW'(1'b1);
                blink_d = blink_q;
            end
        end else begin
            frame_d = frame_q;
            blink_d = blink_q;
        end
    end

    // Display drive for the current digit slot, with blink and leading-zero blanking.
    always_comb begin
        case (digit_q)
            2'd0:    digit_bcd_s = bcd_q[3:0];
            2'd1:    digit_bcd_s = bcd_q[7:4];
            2'd2:    digit_bcd_s = bcd_q[11:8];
            2'd3:    digit_bcd_s = bcd_q[15:12];
            default: digit_bcd_s = 4'h0;
        endcase
        blank_s = paused_s && blink_q;
`ifdef STOPWATCH_DISPLAY_LZB_EN
        lzb_s = (digit_q == 2'd3) && (bcd_q[15:12] == 4'h0);
`else
        lzb_s = 1'b0;
`endif
        if (blank_s || lzb_s) begin
            an_d  = 4'hF;
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
        end else begin
            an_d  = ~(4'b0001 << digit_q);
            seg_d = seg_pol(seg7_pat(digit_bcd_s));
            if (digit_q == 2'd2) dp_d = DP_ON;
            else                 dp_d = DP_OFF;
        end
    end

    // Scan counters, blink state and registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= {RW{1'b0}};
            digit_q   <= 2'd0;
            frame_q   <= {FW{1'b0}};
            blink_q   <= 1'b0;
            an_q      <= 4'hF;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
        end else begin
            if (refresh_wrap_s) begin
                refresh_q <= {RW{1'b0}};
                digit_q   <= digit_q + 2'd1;
            end else begin
                refresh_q <= refresh_q + RW'(1'b1);
            end
            frame_q <= frame_d;
            blink_q <= blink_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;
    assign busy    = busy_q;

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream consumer of stopwatch_top: takes binary minutes/seconds/status and drives a 4-digit multiplexed 7-segment display showing MM.SS.
- Sequential double-dabble BCD converter, digit-scan refresh counter, blink of the whole display while paused.
- Sits between stopwatch_top and board pins; exposes the converted BCD for verification.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit is enabled (>=2).
- BLINK_FRAMES, 64, full 4-digit scan frames per blink half-period (>=1).
- SEG_ACTIVE_LOW, 1, 1: seg/dp asserted low; 0: asserted high (an is always active-low).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- minutes  in  8  binary minutes from stopwatch_top
- seconds  in  6  binary seconds from stopwatch_top
- status  in  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 treated as IDLE
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- an  out  4  digit enables, active-low one-hot; an[0] is the rightmost digit (seconds units)
- bcd_out  out  16  {min_tens, min_units, sec_tens, sec_units}
- ovf  out  1  latched value was clamped
- busy  out  1  converter active

Behaviour:
- Reset (async, rst_n=0): seg and dp off (all 1s if SEG_ACTIVE_LOW), an=4'hF, bcd_out=0, ovf=0, busy=0. Digit index, refresh counter, frame counter and blink phase are all 0. The last-captured registers are 0, so 00:00 needs no conversion.
- Capture: in IDLE, when {minutes,seconds} differs from the last-captured value, snapshot the inputs and go to SHIFT.
  - Clamp at snapshot: minutes>99 becomes 99; seconds>59 becomes 59.
  - The snapshot ovf flag is 1 if either value was clamped.
- Converter FSM: IDLE -> SHIFT (exactly 8 cycles, parallel double-dabble on 8-bit minutes and 6-bit seconds; seconds zero-extended to 8 bits) -> COMMIT (1 cycle: bcd_out and ovf updated) -> IDLE.
  - busy=1 in SHIFT and COMMIT.
  - Input change sampled at edge E: bcd_out holds the new value after edge E+10.
- Input change during SHIFT/COMMIT: the current conversion completes with the old snapshot. In IDLE the compare then fires and a new conversion starts, so the last value always wins. No change is lost, but intermediate values may be skipped.
- Scan:
  - The refresh counter runs 0..REFRESH_DIV-1 continuously. On wrap, the digit index advances 0->1->2->3->0.
  - an drives the digit at the current index low. seg is the 7-segment decode of that digit's BCD from bcd_out.
  - BCD values 10-15 never occur; decode them as blank.
- dp is asserted only while digit 2 (minutes units) is enabled, giving the MM.SS separator.
- Blink:
  - The frame counter increments each time the digit index wraps 3->0. blink_phase toggles when the frame counter reaches BLINK_FRAMES-1, and the counter then resets.
  - While status==PAUSED and blink_phase==1: an=4'hF and seg/dp are off. Scanning counters keep running.
  - On any cycle status is not PAUSED: blink_phase=0 and the frame counter is held at 0. Entering PAUSED therefore always starts in the visible phase.
- Status changes take effect on the next clk edge. Scan timing is independent of conversion.
- Mid-operation reset: all state returns to reset values immediately. The conversion is discarded.

Optional Feature:
- Macro STOPWATCH_DISPLAY_LZB_EN.
- Defined: digit 3 (min_tens) is blanked (an[3] stays high during its slot; seg off) when min_tens==0.
- Undefined: all four digits are always shown, including leading zero, e.g. 05.07.
- bcd_out is identical in both builds.

Test Plan (REFRESH_DIV=4, BLINK_FRAMES=2, SEG_ACTIVE_LOW=1):
- Reset: hold rst_n=0 -> an=4'hF, seg=7'h7F, dp=1, bcd_out=16'h0000, busy=0. Release -> first slot an=4'b1110, seg=7'h40 ("0").
- Conversion latency: minutes=12, seconds=34 applied before edge E -> busy=1 from E through E+9. After edge E+10: bcd_out=16'h1234, ovf=0, busy=0.
- Clamp: minutes=200, seconds=63 -> bcd_out=16'h9959, ovf=1. Then minutes=1, seconds=0 -> bcd_out=16'h0100, ovf=0.
- Retrigger: change to 5/5, then to 6/6 three cycles later -> bcd_out passes through 16'h0505, then settles to 16'h0606. Converter idles afterwards.
- Scan/dp: bcd_out=16'h1234 -> an cycles 1110,1101,1011,0111 every 4 clks. seg shows 4,3,2,1. dp=0 only while an=4'b1011.
- Blink: status=PAUSED -> display visible 2 frames (32 clk), blank 2 frames, repeating. status=RUNNING -> visible immediately. LZB build with bcd_out=16'h0507 -> an[3] never low.
